mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Latency-configurable memory responder for the core's req/gnt memory port.
- Accepts one request per cycle: address, write data, byte strobes, write-enable.
- Returns an in-order response stream (rvalid/rready) after a fixed pipeline latency.
- Asserts grant backpressure when response buffering is exhausted; replaces the always-granted single-cycle SRAM in stall and latency-stress configurations of the tiny SoC.

Parameters:
- NumWords, 1<<16, number of DataWidth-bit words backed by storage.
- AddrWidth, 64, request address width (byte address).
- DataWidth, 64, data word width; must be 64.
- BaseAddr, 64'h80000000, byte address of word 0.
- Latency, 2, cycles from accept edge to earliest rvalid_o; legal range 1..8.
- RespDepth, 4, maximum responses in flight plus buffered; must be >= 1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- mem_req_i  in  1  request valid.
- mem_gnt_o  out  1  request accepted this cycle when mem_req_i is also high.
- mem_addr_i  in  AddrWidth  byte address; bits [2:0] ignored.
- mem_wdata_i  in  DataWidth  write data.
- mem_strb_i  in  DataWidth/8  byte write strobes.
- mem_we_i  in  1  1 = write, 0 = read.
- mem_rvalid_o  out  1  response valid.
- mem_rready_i  in  1  response consumer ready.
- mem_rdata_o  out  DataWidth  read data; 0 for write responses.
- mem_err_o  out  1  response corresponds to an out-of-range address.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i, sampled on the rising edge.
- Reset values: while rst_i is high, and in the first cycle after it is sampled:
  - mem_gnt_o = 0, mem_rvalid_o = 0, mem_rdata_o = 0, mem_err_o = 0.
  - In-flight counter and FIFO pointers are cleared.
  - Storage contents are NOT cleared; they are preloaded by the testbench.
- Reset mid-operation: all pending responses are dropped. A write accepted at the reset edge is not performed.
- Grant:
  - mem_gnt_o = !rst_i && (inflight + fifo_count) < RespDepth.
  - Computed only from registered state; never depends on mem_req_i.
  - Accept = mem_req_i && mem_gnt_o. At most one accept per cycle.
- Address decode:
  - idx = (mem_addr_i - BaseAddr) >> 3.
  - In range iff mem_addr_i >= BaseAddr and idx < NumWords.
- Write (accepted, in range): at the accept edge, update byte k of word idx iff mem_strb_i[k]. strb = 0 is a legal no-op write and still produces a response.
- Read (accepted, in range): data is sampled from storage at the accept edge. A read accepted the cycle after a write to the same word returns the new data.
- Out of range:
  - Write is ignored.
  - Response carries mem_err_o = 1.
  - Read data = 64'hDEADBEEF_DEADBEEF.
- Response pipeline:
  - Each accept launches an entry {rdata, err} through a (Latency-1)-stage shift register.
  - The entry is then pushed into a RespDepth-entry FIFO.
  - Latency = 1 means no shift stages: the entry goes straight into the FIFO.
  - An entry accepted at edge T is visible at the FIFO head no earlier than cycle T+Latency.
- Response output:
  - mem_rvalid_o = FIFO non-empty; head drives mem_rdata_o and mem_err_o.
  - Pop on mem_rvalid_o && mem_rready_i.
  - Outputs hold stable while mem_rvalid_o && !mem_rready_i.
  - mem_rdata_o = 0 and mem_err_o = 0 when mem_rvalid_o = 0.
- Counters and invariant:
  - inflight counts entries in the shift register.
  - inflight + fifo_count <= RespDepth at all times, so the FIFO never overflows.
- Simultaneous events:
  - Accept, FIFO push and pop may all occur in one cycle; counters update by the net change.
  - A full FIFO with a pop in the same cycle does not raise mem_gnt_o that cycle; grant rises the following cycle.
- Ordering: responses are strictly in accept order.

Decomposition:
- Package mem_responder_pkg holds:
  - resp_t struct {rdata: logic[63:0], err: logic}.
  - ErrRdata = 64'hDEADBEEF_DEADBEEF.
  - Function addr_to_idx.
- Sub-module resp_fifo (parametrised depth, type resp_t) contains:
  - Registered pointers, count, full/empty flags.
  - Simultaneous push/pop support.
- Storage array and shift register stay in the top module.

Test Plan:
- Write then read back: write addr 0x80000008, data 0x1122334455667788, strb 0xFF; read the same address → response with rdata 0x1122334455667788, err 0, exactly 2 cycles after accept (Latency=2, rready=1).
- Partial strobe: preload word 0 = 0; write 0xAABBCCDDEEFF0011 with strb 0x0F to 0x80000000 → read returns 0x00000000EEFF0011.
- Out of range:
  - Read 0x7FFFFFF8 → err=1, rdata 0xDEADBEEFDEADBEEF.
  - Write to BaseAddr + NumWords*8, then read word 0 → word 0 unchanged.
- Backpressure: rready=0, req held high → exactly RespDepth=4 grants, then mem_gnt_o=0. Raise rready → 4 in-order responses, and grant returns one cycle after the first pop.
- Back-to-back reads of 4 distinct preloaded words with rready=1 → grant stays 1 every cycle; responses arrive on 4 consecutive cycles in order.
- Reset mid-stream: 3 reads accepted, rst_i high for 1 cycle → no rvalid afterwards, gnt_o=0 in the reset cycle, and a fresh read completes normally afterwards.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the latency-configurable memory responder.
package mem_responder_pkg;

  // One response entry as it travels through the pipeline and FIFO.
  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } resp_t;

  // Read data returned for an out-of-range read.
  localparam logic [63:0] ErrRdata = 64'hDEAD_BEEF_DEAD_BEEF;

  // Word index of a byte address relative to the base of storage.
  function automatic logic [63:0] addr_to_idx(input logic [63:0] addr,
                                              input logic [63:0] base);
    return (addr - base) >> 2'd3;
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// In-order response FIFO with registered pointers, count and flags.
// Push and pop may happen in the same cycle, including while full.
module resp_fifo
  import mem_responder_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  resp_t                        push_data_i,
  input  logic                         pop_i,
  output resp_t                        head_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  resp_t            mem_r [Depth];
  logic [PtrW-1:0]  wptr_r;
  logic [PtrW-1:0]  rptr_r;
  logic [CntW-1:0]  count_r;
  logic [CntW-1:0]  count_next_s;
  logic             empty_r;
  logic             full_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Pointer increment that wraps at Depth (Depth need not be a power of two).
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? {PtrW{1'b0}} : p + 1'b1;
  endfunction

  assign pop_ok_s  = pop_i && !empty_r;
  assign push_ok_s = push_i && (!full_r || pop_ok_s);

  // Net occupancy change for this cycle.
  always_comb begin
    count_next_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + 1'b1;
      2'b01:   count_next_s = count_r - 1'b1;
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, count and flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_r  <= {PtrW{1'b0}};
      rptr_r  <= {PtrW{1'b0}};
      count_r <= {CntW{1'b0}};
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      if (push_ok_s) wptr_r <= next_ptr(wptr_r);
      if (pop_ok_s)  rptr_r <= next_ptr(rptr_r);
      count_r <= count_next_s;
      empty_r <= (count_next_s == {CntW{1'b0}});
      full_r  <= (count_next_s == CntW'(Depth));
    end
  end

  // Entry storage; contents are don't-care until pushed.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) mem_r[wptr_r] <= push_data_i;
  end

  assign head_o  = mem_r[rptr_r];
  assign empty_o = empty_r;
  assign count_o = count_r;

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the core req/gnt port: byte-strobed storage, a fixed
// latency response pipeline and a bounded response FIFO with grant backpressure.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          NumWords  = 32'd65536,
  parameter int          AddrWidth = 32'd64,
  parameter int          DataWidth = 32'd64,
  parameter logic [63:0] BaseAddr  = 64'h0000_0000_8000_0000,
  parameter int          Latency   = 32'd2,
  parameter int          RespDepth = 32'd4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   mem_req_i,
  output logic                   mem_gnt_o,
  input  logic [AddrWidth-1:0]   mem_addr_i,
  input  logic [DataWidth-1:0]   mem_wdata_i,
  input  logic [DataWidth/8-1:0] mem_strb_i,
  input  logic                   mem_we_i,
  output logic                   mem_rvalid_o,
  input  logic                   mem_rready_i,
  output logic [DataWidth-1:0]   mem_rdata_o,
  output logic                   mem_err_o
);

  localparam int IdxW = $clog2(NumWords);
  localparam int FcW  = $clog2(RespDepth + 1);
  localparam int CntW = FcW + 1;
  localparam int StW  = (Latency > 1) ? Latency - 1 : 1;

  logic [DataWidth-1:0] mem_r [NumWords];
  logic [63:0]          addr_s;
  logic [63:0]          idx_s;
  logic [IdxW-1:0]      widx_s;
  logic                 in_range_s;
  logic                 accept_s;
  logic                 wr_en_s;
  logic                 push_s;
  logic                 pop_s;
  resp_t                entry_s;
  resp_t                push_data_s;
  resp_t                head_s;
  logic                 fifo_empty_s;
  logic [FcW-1:0]       fifo_count_s;
  logic [CntW-1:0]      inflight_r;
  logic [CntW-1:0]      inflight_next_s;
  logic [CntW-1:0]      total_next_s;
  logic                 gnt_r;

  // Grant comes from registered occupancy only; reset forces it low at once.
  assign mem_gnt_o = gnt_r && !rst_i;
  assign accept_s  = mem_req_i && mem_gnt_o;
  assign addr_s    = 64'(mem_addr_i);

  // Address decode into a word index and range check.
  always_comb begin
    idx_s      = addr_to_idx(addr_s, BaseAddr);
    in_range_s = (addr_s >= BaseAddr) && (idx_s < 64'(NumWords));
    widx_s     = idx_s[IdxW-1:0];
  end

  assign wr_en_s = accept_s && mem_we_i && in_range_s;

  // Build the response entry; reads see storage before this edge's write.
  always_comb begin
    entry_s.err = !in_range_s;
    if (mem_we_i) begin
      entry_s.rdata = 64'd0;
    end else if (!in_range_s) begin
      entry_s.rdata = ErrRdata;
    end else begin
      entry_s.rdata = mem_r[widx_s];
    end
  end

  // Byte-strobed storage write; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      for (int k = 0; k < DataWidth / 8; k++) begin
        if (mem_strb_i[k]) mem_r[widx_s][8*k +: 8] <= mem_wdata_i[8*k +: 8];
      end
    end
  end

  if (Latency > 1) begin : g_shift
    logic [StW-1:0] vld_r;
    resp_t          dat_r [StW];

    // Valid bits of the latency shift register.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_r <= {StW{1'b0}};
      end else begin
        vld_r[0] <= accept_s;
        for (int k = 1; k < StW; k++) vld_r[k] <= vld_r[k-1];
      end
    end

    // Payload of the latency shift register; qualified by vld_r.
    always_ff @(posedge clk_i) begin
      dat_r[0] <= entry_s;
      for (int k = 1; k < StW; k++) dat_r[k] <= dat_r[k-1];
    end

    assign push_s      = vld_r[StW-1];
    assign push_data_s = dat_r[StW-1];
  end else begin : g_direct
    assign push_s      = accept_s;
    assign push_data_s = entry_s;
  end

  assign pop_s = !fifo_empty_s && mem_rready_i;

  // Next-cycle occupancy of shift register plus FIFO.
  always_comb begin
    inflight_next_s = inflight_r + CntW'(accept_s) - CntW'(push_s);
    total_next_s    = inflight_next_s + CntW'(fifo_count_s) + CntW'(push_s) - CntW'(pop_s);
  end

  // In-flight counter and registered grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_r <= {CntW{1'b0}};
      gnt_r      <= 1'b0;
    end else begin
      inflight_r <= inflight_next_s;
      gnt_r      <= (total_next_s < CntW'(RespDepth));
    end
  end

  resp_fifo #(
    .Depth (RespDepth)
  ) u_resp_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push_s),
    .push_data_i (push_data_s),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .empty_o     (fifo_empty_s),
    .count_o     (fifo_count_s)
  );

  // Response outputs are zero whenever no response is valid.
  always_comb begin
    mem_rvalid_o = !fifo_empty_s;
    if (fifo_empty_s) begin
      mem_rdata_o = {DataWidth{1'b0}};
      mem_err_o   = 1'b0;
    end else begin
      mem_rdata_o = head_s.rdata;
      mem_err_o   = head_s.err;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (Latency=2, RespDepth=4).
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        req;
  logic        gnt;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  strb;
  logic        we;
  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  logic        err;

  int pass_cnt;
  int total_cnt;

  localparam logic [63:0] Base = 64'h0000_0000_8000_0000;
  localparam logic [63:0] W16  = 64'h0000_0000_8000_0080;

  mem_responder dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .mem_req_i    (req),
    .mem_gnt_o    (gnt),
    .mem_addr_i   (addr),
    .mem_wdata_i  (wdata),
    .mem_strb_i   (strb),
    .mem_we_i     (we),
    .mem_rvalid_o (rvalid),
    .mem_rready_i (rready),
    .mem_rdata_o  (rdata),
    .mem_err_o    (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Word value preloaded at index 16+i.
  function automatic logic [63:0] wval(input int i);
    return 64'hC0DE_0000_0000_0010 + 64'(i);
  endfunction

  // Issue one request starting at a negedge; returns at the negedge after the accept cycle.
  task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] d,
                       input logic [7:0] s, output bit ok);
    ok = 1'b0;
    req = 1'b1; we = w; addr = a; wdata = d; strb = s;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (gnt) ok = 1'b1;
      @(negedge clk);
    end
    req = 1'b0; we = 1'b0;
  endtask

  // Write and let its response drain (rready assumed high).
  task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                    output bit ok);
    issue(1'b1, a, d, s, ok);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b0; we = 1'b0; rready = 1'b1;
    addr = 64'd0; wdata = 64'd0; strb = 8'd0;
    repeat (3) @(negedge clk);
    #1;
    total_cnt++; if (gnt !== 1'b0) $display("FAIL rst_gnt: got %b want 0", gnt); else pass_cnt++;
    total_cnt++; if (rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b want 0", rvalid); else pass_cnt++;
    total_cnt++; if (rdata !== 64'd0) $display("FAIL rst_rdata: got %h want 0", rdata); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total_cnt++; if (gnt !== 1'b1) $display("FAIL post_rst_gnt: got %b want 1", gnt); else pass_cnt++;
    total_cnt++; if (rvalid !== 1'b0) $display("FAIL post_rst_rvalid: got %b want 0", rvalid); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    bit ok1, ok2;
    wr(64'h0000_0000_8000_0008, 64'h1122_3344_5566_7788, 8'hFF, ok1);
    issue(1'b0, 64'h0000_0000_8000_0008, 64'd0, 8'd0, ok2);
    total_cnt++; if (!(ok1 && ok2)) $display("FAIL wr_rd_grant: got %b%b want 11", ok1, ok2); else pass_cnt++;
    #1;
    total_cnt++; if (rvalid !== 1'b0) $display("FAIL wr_rd_early: got rvalid %b want 0 one cycle after accept", rvalid); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if ({rvalid, err, rdata} !== {1'b1, 1'b0, 64'h1122_3344_5566_7788})
      $display("FAIL wr_rd_resp: got v=%b e=%b d=%h want v=1 e=0 d=1122334455667788", rvalid, err, rdata);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_partial_strobe;
    bit ok1, ok2, ok3;
    wr(Base, 64'd0, 8'hFF, ok1);
    wr(Base, 64'hAABB_CCDD_EEFF_0011, 8'h0F, ok2);
    issue(1'b0, Base, 64'd0, 8'd0, ok3);
    total_cnt++; if (!(ok1 && ok2 && ok3)) $display("FAIL strb_grant: got %b%b%b want 111", ok1, ok2, ok3); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if ({rvalid, rdata} !== {1'b1, 64'h0000_0000_EEFF_0011})
      $display("FAIL strb_resp: got v=%b d=%h want v=1 d=00000000eeff0011", rvalid, rdata);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_out_of_range;
    bit ok1, ok2, ok3;
    issue(1'b0, 64'h0000_0000_7FFF_FFF8, 64'd0, 8'd0, ok1);
    @(negedge clk); #1;
    total_cnt++; if ({rvalid, err, rdata} !== {1'b1, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF})
      $display("FAIL oor_read: got v=%b e=%b d=%h want v=1 e=1 d=deadbeefdeadbeef", rvalid, err, rdata);
    else pass_cnt++;
    @(negedge clk);
    wr(64'h0000_0000_8008_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, ok2);
    issue(1'b0, Base, 64'd0, 8'd0, ok3);
    total_cnt++; if (!(ok1 && ok2 && ok3)) $display("FAIL oor_grant: got %b%b%b want 111", ok1, ok2, ok3); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if ({rvalid, err, rdata} !== {1'b1, 1'b0, 64'h0000_0000_EEFF_0011})
      $display("FAIL oor_word0: got v=%b e=%b d=%h want v=1 e=0 d=00000000eeff0011", rvalid, err, rdata);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    bit ok_all, ok;
    bit g;
    int grants;
    ok_all = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr(W16 + 64'(8 * i), wval(i), 8'hFF, ok);
      ok_all = ok_all && ok;
    end
    total_cnt++; if (!ok_all) $display("FAIL bp_preload: got %b want 1", ok_all); else pass_cnt++;
    rready = 1'b0; req = 1'b1; we = 1'b0; addr = W16; grants = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      g = gnt;
      if (g) grants++;
      @(negedge clk);
      if (g) addr = addr + 64'd8;
    end
    req = 1'b0;
    total_cnt++; if (grants != 4) $display("FAIL bp_grants: got %0d want 4", grants); else pass_cnt++;
    rready = 1'b1;
    #1;
    total_cnt++; if (gnt !== 1'b0) $display("FAIL bp_gnt_full: got %b want 0", gnt); else pass_cnt++;
    total_cnt++; if ({rvalid, rdata} !== {1'b1, wval(0)})
      $display("FAIL bp_resp0: got v=%b d=%h want v=1 d=%h", rvalid, rdata, wval(0));
    else pass_cnt++;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); #1;
      if (k == 1) begin
        total_cnt++; if (gnt !== 1'b1) $display("FAIL bp_gnt_return: got %b want 1", gnt); else pass_cnt++;
      end
      total_cnt++; if ({rvalid, rdata} !== {1'b1, wval(k)})
        $display("FAIL bp_resp%0d: got v=%b d=%h want v=1 d=%h", k, rvalid, rdata, wval(k));
      else pass_cnt++;
    end
    @(negedge clk); #1;
    total_cnt++; if (rvalid !== 1'b0) $display("FAIL bp_drained: got %b want 0", rvalid); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    rready = 1'b1; req = 1'b1; we = 1'b0; addr = W16;
    for (int c = 0; c < 7; c++) begin
      #1;
      if (c < 4) begin
        total_cnt++; if (gnt !== 1'b1) $display("FAIL b2b_gnt%0d: got %b want 1", c, gnt); else pass_cnt++;
      end
      if (c >= 2 && c < 6) begin
        total_cnt++; if ({rvalid, rdata} !== {1'b1, wval(c - 2)})
          $display("FAIL b2b_resp%0d: got v=%b d=%h want v=1 d=%h", c - 2, rvalid, rdata, wval(c - 2));
        else pass_cnt++;
      end
      if (c == 6) begin
        total_cnt++; if (rvalid !== 1'b0) $display("FAIL b2b_tail: got %b want 0", rvalid); else pass_cnt++;
      end
      @(negedge clk);
      if (c < 3) addr = addr + 64'd8;
      else req = 1'b0;
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int seen;
    rready = 1'b1; req = 1'b1; we = 1'b0; addr = W16;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      addr = addr + 64'd8;
    end
    req = 1'b0; rst = 1'b1;
    #1;
    total_cnt++; if (gnt !== 1'b0) $display("FAIL mid_rst_gnt: got %b want 0", gnt); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (rvalid) seen++;
      @(negedge clk);
    end
    total_cnt++; if (seen != 0) $display("FAIL mid_rst_dropped: got %0d rvalid cycles want 0", seen); else pass_cnt++;
    issue(1'b0, W16 + 64'd8, 64'd0, 8'd0, ok);
    total_cnt++; if (!ok) $display("FAIL mid_rst_regrant: got %b want 1", ok); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if ({rvalid, err, rdata} !== {1'b1, 1'b0, wval(1)})
      $display("FAIL mid_rst_fresh: got v=%b e=%b d=%h want v=1 e=0 d=%h", rvalid, err, rdata, wval(1));
    else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_out_of_range();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
